// File: rtl/phy_rx_sp.sv
// ---------------------------------------------------------------------------
// phy_rx_sp -- receive-side serial-to-parallel front end of the PCI PHY.
//
// Samples a 1-bit serial lane (MSB of each symbol first) on every rising edge
// of clk_32f. It hunts for the COM symbol at any bit offset, then checks that
// COM repeats on every following byte boundary. After COM_LOCK aligned COMs
// the link is declared active. From then on, data bytes are recovered and
// reassembled MSB-byte first into 32-bit words.
//
// Parameters:
//   COM       comma/alignment symbol (default 8'hBC)
//   IDL       idle symbol            (default 8'h7C)
//   COM_LOCK  consecutive aligned COMs needed to go active (1..15)
//
// Ports:
//   clk_32f        in   1   bit clock, rising edge
//   reset          in   1   asynchronous, active-low; clears all state
//   data_in        in   1   serial lane
//   active_out     out  1   link aligned and active
//   data_out_sp1   out  8   last recovered data byte
//   valid_out_sp1  out  1   one-cycle strobe, new byte on data_out_sp1
//   data_out       out  32  last assembled word
//   valid_out      out  1   one-cycle strobe, new word on data_out
//
// Build option:
//   PHY_RX_IDL_FILTER_EN  when defined, IDL is treated like COM once the link
//                         is active: no strobe, and the partial word is dropped.
//                         When undefined, IDL is delivered as ordinary data.
// ---------------------------------------------------------------------------
module phy_rx_sp #(
  parameter logic [7:0]  COM      = 8'hBC,
  parameter logic [7:0]  IDL      = 8'h7C,
  parameter int unsigned COM_LOCK = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_in,
  output logic        active_out,
  output logic [7:0]  data_out_sp1,
  output logic        valid_out_sp1,
  output logic [31:0] data_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {SEARCH, SYNC, ACTIVE} state_t;

  localparam logic [3:0] LOCK = 4'(COM_LOCK);

`ifdef PHY_RX_IDL_FILTER_EN
  localparam logic IDL_FILTER = 1'b1;
`else
  localparam logic IDL_FILTER = 1'b0;
`endif

  state_t      state_reg, state_next;
  logic [6:0]  sr_reg;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [3:0]  com_cnt_reg, com_cnt_next;
  logic [1:0]  byte_idx_reg, byte_idx_next;
  logic [23:0] word_reg, word_next;      // bytes 0..2 of the word in progress
  logic [7:0]  dsp1_reg, dsp1_next;
  logic        vsp1_reg, vsp1_next;
  logic [31:0] dout_reg, dout_next;
  logic        vout_reg, vout_next;

  logic [7:0]  w;
  logic        is_com;
  logic        non_data;
  logic        boundary;
  logic        take_byte;
  logic [2:0]  lane_we;

  // Byte that completes on this edge: the seven previous bits plus the bit
  // being sampled now.
  assign w         = {sr_reg, data_in};
  assign is_com    = (w == COM);
  assign non_data  = is_com || (IDL_FILTER && (w == IDL));
  assign boundary  = (bit_cnt_reg == 3'd7);
  assign take_byte = (state_reg == ACTIVE) && boundary && !non_data;

  // One write lane per buffered byte. The fourth byte goes straight to
  // data_out, so it needs no buffer.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      assign lane_we[gi] = take_byte && (byte_idx_reg == 2'(gi));
      assign word_next[23-8*gi -: 8] = lane_we[gi] ? w : word_reg[23-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg + 3'd1;
    com_cnt_next  = com_cnt_reg;
    byte_idx_next = byte_idx_reg;
    dsp1_next     = dsp1_reg;
    vsp1_next     = 1'b0;
    dout_next     = dout_reg;
    vout_next     = 1'b0;

    case (state_reg)
      SEARCH: begin
        // While hunting, the bit counter is held so that it is already
        // aligned when a COM is found.
        bit_cnt_next = 3'd0;
        if (is_com) begin
          com_cnt_next = 4'd1;
          state_next   = (LOCK == 4'd1) ? ACTIVE : SYNC;
        end
      end

      SYNC: begin
        if (boundary) begin
          if (is_com) begin
            com_cnt_next = com_cnt_reg + 4'd1;
            if (com_cnt_reg + 4'd1 == LOCK) begin
              state_next = ACTIVE;
            end
          end else begin
            com_cnt_next = 4'd0;
            state_next   = SEARCH;
          end
        end
      end

      ACTIVE: begin
        // Once active, the link stays active until reset, with no
        // loss-of-lock detection.
        if (boundary) begin
          if (non_data) begin
            byte_idx_next = 2'd0;
          end else begin
            dsp1_next = w;
            vsp1_next = 1'b1;
            if (byte_idx_reg == 2'd3) begin
              dout_next     = {word_reg, w};
              vout_next     = 1'b1;
              byte_idx_next = 2'd0;
            end else begin
              byte_idx_next = byte_idx_reg + 2'd1;
            end
          end
        end
      end

      default: begin
        state_next = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_reg    <= SEARCH;
      sr_reg       <= 7'd0;
      bit_cnt_reg  <= 3'd0;
      com_cnt_reg  <= 4'd0;
      byte_idx_reg <= 2'd0;
      word_reg     <= 24'd0;
      dsp1_reg     <= 8'h00;
      vsp1_reg     <= 1'b0;
      dout_reg     <= 32'h0;
      vout_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sr_reg       <= w[6:0];
      bit_cnt_reg  <= bit_cnt_next;
      com_cnt_reg  <= com_cnt_next;
      byte_idx_reg <= byte_idx_next;
      word_reg     <= word_next;
      dsp1_reg     <= dsp1_next;
      vsp1_reg     <= vsp1_next;
      dout_reg     <= dout_next;
      vout_reg     <= vout_next;
    end
  end

  assign active_out    = (state_reg == ACTIVE);
  assign data_out_sp1  = dsp1_reg;
  assign valid_out_sp1 = vsp1_reg;
  assign data_out      = dout_reg;
  assign valid_out     = vout_reg;

endmodule

// File: tb/tb_phy_rx_sp.sv
// ---------------------------------------------------------------------------
// tb_phy_rx_sp -- self-checking bench for phy_rx_sp.
//
// Each segment starts from reset and drives a bit stream built from symbols.
// A reference model scans that stream for the alignment point and for the
// byte boundaries that follow it. From this it derives the expected
// per-cycle outputs, and every cycle is compared against the DUT. The
// directed segments add fixed-value checks on top of the per-cycle
// comparisons.
// ---------------------------------------------------------------------------
module tb_phy_rx_sp;

  localparam logic [7:0] COM      = 8'hBC;
  localparam logic [7:0] IDL      = 8'h7C;
  localparam int         COM_LOCK = 4;

`ifdef PHY_RX_IDL_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk_32f = 1'b0;
  logic        reset   = 1'b0;
  logic        data_in = 1'b0;
  logic        active_out;
  logic [7:0]  data_out_sp1;
  logic        valid_out_sp1;
  logic [31:0] data_out;
  logic        valid_out;

  always #5 clk_32f = ~clk_32f;

  phy_rx_sp #(.COM(COM), .IDL(IDL), .COM_LOCK(COM_LOCK)) dut (
    .clk_32f      (clk_32f),
    .reset        (reset),
    .data_in      (data_in),
    .active_out   (active_out),
    .data_out_sp1 (data_out_sp1),
    .valid_out_sp1(valid_out_sp1),
    .data_out     (data_out),
    .valid_out    (valid_out)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  bit          seq[$];
  logic        e_act[$];
  logic        e_vsp1[$];
  logic        e_v[$];
  logic [7:0]  e_dsp1[$];
  logic [31:0] e_d[$];

  int          obs_bytes;
  int          obs_words;
  int          first_act;
  int          has12;
  logic [31:0] last_word;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) seq.push_back(b[k]);
  endtask

  task automatic push_com(input int n);
    for (int k = 0; k < n; k++) push_byte(COM);
  endtask

  task automatic push_junk(input int n);
    for (int k = 0; k < n; k++) seq.push_back(1'($urandom_range(0, 1)));
  endtask

  // Eight bits ending at stream index i. Before the stream starts the line
  // holds the post-reset zeros.
  function automatic logic [7:0] win(input int i);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = i - 7 + k;
      r = {r[6:0], (idx >= 0) ? logic'(seq[idx]) : 1'b0};
    end
    return r;
  endfunction

  // Reference model. First find the stream index of the last bit of the
  // COM_LOCK-th consecutive COM. Every 8th index after that is a byte
  // boundary, and the expected outputs follow from those boundaries.
  task automatic build_expect();
    int          n, act_at, i, j, cnt, widx;
    logic [7:0]  d8, b;
    logic [31:0] d32;
    logic [7:0]  wb[3];
    logic        vs, vw;
    n = seq.size(); act_at = -1; i = 0; widx = 0; d8 = 8'h00; d32 = 32'h0;
    e_act.delete(); e_vsp1.delete(); e_v.delete(); e_dsp1.delete(); e_d.delete();
    while (i < n && act_at < 0) begin
      if (win(i) == COM) begin
        cnt = 1; j = i;
        while (cnt < COM_LOCK && j + 8 < n && win(j + 8) == COM) begin
          j += 8; cnt++;
        end
        if (cnt == COM_LOCK) act_at = j;
        else if (j + 8 < n)  i = j + 9;   // boundary failed at j+8, hunt resumes after it
        else                 i = n;
      end else begin
        i++;
      end
    end
    for (int c = 0; c < n; c++) begin
      vs = 1'b0; vw = 1'b0;
      if (act_at >= 0 && c > act_at && ((c - act_at) % 8) == 0) begin
        b = win(c);
        if (b == COM || (FILT && b == IDL)) begin
          widx = 0;
        end else begin
          vs = 1'b1; d8 = b;
          if (widx == 3) begin
            d32 = {wb[0], wb[1], wb[2], b}; vw = 1'b1; widx = 0;
          end else begin
            wb[widx] = b; widx++;
          end
        end
      end
      e_act.push_back(act_at >= 0 && c >= act_at);
      e_vsp1.push_back(vs);
      e_v.push_back(vw);
      e_dsp1.push_back(d8);
      e_d.push_back(d32);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_act"},  active_out,    32'h0);
    chk({tag, "_dsp1"}, data_out_sp1,  32'h0);
    chk({tag, "_vsp1"}, valid_out_sp1, 32'h0);
    chk({tag, "_d"},    data_out,      32'h0);
    chk({tag, "_v"},    valid_out,     32'h0);
  endtask

  task automatic run_seg(input string name);
    reset = 1'b0; data_in = 1'b0;
    repeat (3) @(posedge clk_32f);
    #1;
    chk_zero("rst");
    reset = 1'b1;
    build_expect();
    obs_bytes = 0; obs_words = 0; first_act = -1; has12 = 0; last_word = 32'h0;
    for (int c = 0; c < seq.size(); c++) begin
      cyc = c;
      data_in = seq[c];
      @(posedge clk_32f);
      #1;
      chk("act",  active_out,    e_act[c]);
      chk("vsp1", valid_out_sp1, e_vsp1[c]);
      chk("dsp1", data_out_sp1,  e_dsp1[c]);
      chk("v",    valid_out,     e_v[c]);
      chk("d",    data_out,      e_d[c]);
      if (valid_out_sp1) obs_bytes++;
      if (valid_out) begin
        obs_words++;
        last_word = data_out;
        if (data_out[31:24] == 8'h12 || data_out[23:16] == 8'h12 ||
            data_out[15:8] == 8'h12 || data_out[7:0] == 8'h12) has12++;
      end
      if (active_out && first_act < 0) first_act = c;
    end
    $display("seg %s: bits=%0d bytes=%0d words=%0d last_word=%h",
             name, seq.size(), obs_bytes, obs_words, last_word);
  endtask

  initial begin
    int          nc, nb, r;
    logic [7:0]  b;
    logic [31:0] exp_w;

    // Basic lock and one word.
    seq.delete(); push_com(4);
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC); push_byte(8'hDD);
    run_seg("basic");
    chk("s1_first_act", first_act, 31);
    chk("s1_bytes", obs_bytes, 4);
    chk("s1_words", obs_words, 1);
    chk("s1_word", last_word, 32'hAABBCCDD);

    // Alignment found behind a 3-bit offset.
    seq.delete(); seq.push_back(1'b0); seq.push_back(1'b1); seq.push_back(1'b1);
    push_com(4);
    push_byte(8'hFF); push_byte(8'hFF); push_byte(8'hEE); push_byte(8'hEE);
    run_seg("offset");
    chk("s2_word", last_word, 32'hFFFFEEEE);
    chk("s2_first_act", first_act, 34);

    // A broken COM run drops back to the hunt, then relocks.
    seq.delete(); push_com(2); push_byte(8'h3F); push_com(4); push_byte(8'h55);
    run_seg("relock");
    chk("s3_first_act", first_act, 55);
    chk("s3_bytes", obs_bytes, 1);

    // A COM in the middle of a word discards the partial word.
    seq.delete(); push_com(4);
    push_byte(8'h12); push_byte(8'h34); push_byte(COM);
    push_byte(8'h56); push_byte(8'h78); push_byte(8'h9A); push_byte(COM);
    push_byte(8'hDE); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    run_seg("discard");
    chk("s4_words", obs_words, 1);
    chk("s4_word", last_word, 32'hDE010203);
    chk("s4_no12", has12, 0);

    // IDL handling depends on the build option.
    seq.delete(); push_com(4);
    push_byte(IDL); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    run_seg("idle");
    chk("s5_bytes", obs_bytes, FILT ? 3 : 4);
    chk("s5_words", obs_words, FILT ? 0 : 1);
    chk("s5_word", last_word, FILT ? 32'h0 : 32'h7C112233);

    // Asynchronous reset in the middle of a word.
    seq.delete(); push_com(4); push_byte(8'h11); push_byte(8'h22); push_junk(3);
    run_seg("midword");
    chk("s6_act_before", active_out, 1);
    reset = 1'b0;
    #1;
    chk_zero("async");
    seq.delete(); push_com(4);
    exp_w = 32'h0;
    for (int k = 0; k < 4; k++) begin
      do b = 8'($urandom); while (b == COM || b == IDL);
      exp_w = {exp_w[23:0], b};
      push_byte(b);
    end
    run_seg("fresh");
    chk("s7_words", obs_words, 1);
    chk("s7_word", last_word, exp_w);

    // Random streams: offsets, short or corrupted COM runs, mixed symbols.
    for (int s = 0; s < 40; s++) begin
      seq.delete();
      push_junk($urandom_range(0, 7));
      nc = $urandom_range(1, 6);
      for (int k = 0; k < nc; k++) begin
        if ($urandom_range(0, 7) == 0) push_byte(8'($urandom));
        else                           push_byte(COM);
      end
      nb = $urandom_range(4, 12);
      for (int k = 0; k < nb; k++) begin
        r = $urandom_range(0, 9);
        b = (r == 0) ? COM : (r == 1) ? IDL : 8'($urandom);
        push_byte(b);
      end
      run_seg("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
